// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the execute-stage issue controller and its helpers.
// Holds ALU opcode constants, branch condition codes, flag-update modes,
// architectural flag bit positions and the sequencer state type.
package alu_issue_ctrl_pkg;

  // ALU opcodes as carried on id_alu_ctrl / alu_control
  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_XOR    = 3'd2;
  localparam logic [2:0] ALU_PADDSB = 3'd3;
  localparam logic [2:0] ALU_SLL    = 3'd4;
  localparam logic [2:0] ALU_SRA    = 3'd5;
  localparam logic [2:0] ALU_ROR    = 3'd6;
  localparam logic [2:0] ALU_LDHALF = 3'd7;  // LHB/LLB, uses alu_load_half_imm

  // Branch condition codes
  typedef enum logic [2:0] {
    COND_NEQ    = 3'b000,
    COND_EQ     = 3'b001,
    COND_GT     = 3'b010,
    COND_LT     = 3'b011,
    COND_GTE    = 3'b100,
    COND_LTE    = 3'b101,
    COND_OVFL   = 3'b110,
    COND_UNCOND = 3'b111
  } cond_e;

  // Which architectural flags an ALU op is allowed to write
  typedef enum logic [1:0] {
    FM_NONE = 2'b00,
    FM_Z    = 2'b01,
    FM_ZVN  = 2'b10,
    FM_RSVD = 2'b11   // behaves as FM_NONE
  } flag_mode_e;

  // Bit positions inside the {Z,V,N} flag vector
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issue_ctrl_branch_cond_eval.sv
// Combinational branch condition resolver.
// Ports:
//   i_cond  - 3-bit condition code (cond_e)
//   i_flags - architectural {Z,V,N}
//   o_taken - 1 when the condition holds
module alu_issue_ctrl_branch_cond_eval
  import alu_issue_ctrl_pkg::*;
(
  input  logic [2:0] i_cond,
  input  logic [2:0] i_flags,
  output logic       o_taken
);

  logic w_z;
  logic w_v;
  logic w_n;

  assign w_z = i_flags[FLAG_Z];
  assign w_v = i_flags[FLAG_V];
  assign w_n = i_flags[FLAG_N];

  always_comb begin
    o_taken = 1'b0;
    case (cond_e'(i_cond))
      COND_NEQ:    o_taken = ~w_z;
      COND_EQ:     o_taken = w_z;
      COND_GT:     o_taken = ~w_z & ~w_n;
      COND_LT:     o_taken = w_n;
      COND_GTE:    o_taken = w_z | ~w_n;
      COND_LTE:    o_taken = w_n | w_z;
      COND_OVFL:   o_taken = w_v;
      COND_UNCOND: o_taken = 1'b1;
      default:     o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer in front of the ALU.
// Takes one decoded instruction at a time (id_valid/id_ready), drives the ALU
// with registered operands, waits for alu_done (with a timeout), owns the
// {Z,V,N} flag register, resolves branches against it and presents results
// downstream (ex_valid/ex_ready).
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   id_*                - decoded instruction and handshake from decode
//   alu_*  (out)        - registered operands/opcode to the ALU
//   alu_done/result/flags - ALU response
//   ex_*                - result handshake to the memory stage
//   flags               - architectural {Z,V,N}
//   err_timeout         - sticky ALU timeout fault
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [2:0]        id_alu_ctrl,
  input  logic [DATA_W-1:0] id_data_one,
  input  logic [DATA_W-1:0] id_data_two,
  input  logic [3:0]        id_shift,
  input  logic [7:0]        id_imm8,
  input  logic [1:0]        id_flag_mode,
  input  logic              id_is_branch,
  input  logic [2:0]        id_cond,
  input  logic [3:0]        id_dst,
  output logic [DATA_W-1:0] alu_data_one,
  output logic [DATA_W-1:0] alu_data_two,
  output logic [3:0]        alu_shift,
  output logic [7:0]        alu_load_half_imm,
  output logic [2:0]        alu_control,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [2:0]        alu_flags,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_result,
  output logic [3:0]        ex_dst,
  output logic              ex_branch_taken,
  output logic [2:0]        flags,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  flag_mode_e       r_mode;
  logic [3:0]       r_dst;

  logic             w_accept;
  logic             w_taken;
  logic [CNT_W-1:0] w_cnt_inc;

  assign id_ready  = (r_state == ST_IDLE) | ((r_state == ST_HOLD) & ex_ready);
  assign w_accept  = id_valid & id_ready;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Branches resolve against the flag register as it stands; since flags are
  // written on ISSUE exit, a branch accepted in HOLD sees the prior op's flags.
  alu_issue_ctrl_branch_cond_eval u_cond (
    .i_cond  (id_cond),
    .i_flags (flags),
    .o_taken (w_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= ST_IDLE;
      r_cnt             <= '0;
      r_mode            <= FM_NONE;
      r_dst             <= '0;
      alu_data_one      <= '0;
      alu_data_two      <= '0;
      alu_shift         <= '0;
      alu_load_half_imm <= '0;
      alu_control       <= '0;
      ex_valid          <= 1'b0;
      ex_result         <= '0;
      ex_dst            <= '0;
      ex_branch_taken   <= 1'b0;
      flags             <= '0;
      err_timeout       <= 1'b0;
    end else begin
      case (r_state)
        // IDLE and HOLD share the accept path; HOLD additionally retires the
        // presented result when ex_ready is high and nothing new arrives.
        ST_IDLE, ST_HOLD: begin
          if (w_accept) begin
            if (id_is_branch) begin
              ex_branch_taken <= w_taken;
              ex_result       <= '0;
              ex_dst          <= id_dst;
              ex_valid        <= 1'b1;
              r_state         <= ST_HOLD;
            end else begin
              alu_data_one      <= id_data_one;
              alu_data_two      <= id_data_two;
              alu_shift         <= id_shift;
              alu_load_half_imm <= id_imm8;
              alu_control       <= id_alu_ctrl;
              r_mode            <= flag_mode_e'(id_flag_mode);
              r_dst             <= id_dst;
              r_cnt             <= '0;
              ex_valid          <= 1'b0;
              r_state           <= ST_ISSUE;
            end
          end else if ((r_state == ST_HOLD) && ex_ready) begin
            ex_valid <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end

        ST_ISSUE: begin
          if (alu_done) begin
            ex_result       <= alu_result;
            ex_dst          <= r_dst;
            ex_branch_taken <= 1'b0;
            ex_valid        <= 1'b1;
            r_state         <= ST_HOLD;
            case (r_mode)
              FM_Z:    flags[FLAG_Z] <= alu_flags[FLAG_Z];
              FM_ZVN:  flags         <= alu_flags;
              default: ;
            endcase
          end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
            err_timeout     <= 1'b1;
            ex_result       <= '0;
            ex_dst          <= r_dst;
            ex_branch_taken <= 1'b0;
            ex_valid        <= 1'b1;
            r_state         <= ST_HOLD;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
